// File: rtl/stream_pkt_dispatch_if.sv
// Packet stream bundle: one beat per tvalid/tready handshake, framed by tstart/tlast.
// A beat transfers on a rising edge where tvalid && tready; the master holds all fields stable while tvalid && !tready.
interface stream_pkt_dispatch_if #(
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256
);
    logic                   tvalid;
    logic                   tstart;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tready;

    modport master (
        output tvalid, tstart, tlast, tuser, tdata,
        input  tready
    );

    modport slave (
        input  tvalid, tstart, tlast, tuser, tdata,
        output tready
    );
endinterface

// File: rtl/stream_pkt_dispatch.sv
// Routes each packet from the in_reg stream to out0, out1 or a silent drop, based on a tuser field decoded on the start beat.
// Orphan beats and dropped packets are tallied in saturating counters.
module stream_pkt_dispatch #(
    parameter int TUSER_WIDTH = 128,
    parameter int TDATA_WIDTH = 256,
    parameter int DEST_LSB    = 0,
    parameter int DEST_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    stream_pkt_dispatch_if.slave          in_reg,
    stream_pkt_dispatch_if.master         out0,
    stream_pkt_dispatch_if.master         out1,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   err_cnt,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD0 = 2'd1,
        FWD1 = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                state;
    logic [DEST_WIDTH-1:0] dest;
    logic                  dest0;
    logic                  dest1;
    logic                  slot0_free;
    logic                  slot1_free;
    logic                  ready_sel;
    logic                  accept;
    logic                  load0;
    logic                  load1;

    assign state_dbg = state;

    // Ready is never offered without tvalid, because the upstream FIFO pops on ready.
    always_comb begin
        dest       = in_reg.tuser[DEST_LSB +: DEST_WIDTH];
        dest0      = (dest == DEST_WIDTH'(0));
        dest1      = (dest == DEST_WIDTH'(1));
        slot0_free = !out0.tvalid || out0.tready;
        slot1_free = !out1.tvalid || out1.tready;
        ready_sel  = 1'b1;
        case (state)
            IDLE: begin
                if (in_reg.tstart && dest0)
                    ready_sel = slot0_free;
                else if (in_reg.tstart && dest1)
                    ready_sel = slot1_free;
            end
            FWD0:    ready_sel = slot0_free;
            FWD1:    ready_sel = slot1_free;
            default: ready_sel = 1'b1;
        endcase
        accept        = !rst && in_reg.tvalid && ready_sel;
        in_reg.tready = accept;
        load0 = accept && (((state == IDLE) && in_reg.tstart && dest0) || (state == FWD0));
        load1 = accept && (((state == IDLE) && in_reg.tstart && dest1) || (state == FWD1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out0.tvalid <= 1'b0;
            out0.tstart <= 1'b0;
            out0.tlast  <= 1'b0;
            out0.tuser  <= {TUSER_WIDTH{1'b0}};
            out0.tdata  <= {TDATA_WIDTH{1'b0}};
            out1.tvalid <= 1'b0;
            out1.tstart <= 1'b0;
            out1.tlast  <= 1'b0;
            out1.tuser  <= {TUSER_WIDTH{1'b0}};
            out1.tdata  <= {TDATA_WIDTH{1'b0}};
            drop_cnt    <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            // A load in the same cycle as a drain keeps tvalid high with the new beat.
            if (load0) begin
                out0.tvalid <= 1'b1;
                out0.tstart <= in_reg.tstart;
                out0.tlast  <= in_reg.tlast;
                out0.tuser  <= in_reg.tuser;
                out0.tdata  <= in_reg.tdata;
            end else if (out0.tready) begin
                out0.tvalid <= 1'b0;
            end

            if (load1) begin
                out1.tvalid <= 1'b1;
                out1.tstart <= in_reg.tstart;
                out1.tlast  <= in_reg.tlast;
                out1.tuser  <= in_reg.tuser;
                out1.tdata  <= in_reg.tdata;
            end else if (out1.tready) begin
                out1.tvalid <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!in_reg.tstart) begin
                            if (err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                        end else if (dest0) begin
                            if (!in_reg.tlast)
                                state <= FWD0;
                        end else if (dest1) begin
                            if (!in_reg.tlast)
                                state <= FWD1;
                        end else begin
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                            if (!in_reg.tlast)
                                state <= DROP;
                        end
                    end
                    // A mid-packet tstart is forwarded as a continuation, never re-decoded.
                    default: begin
                        if (in_reg.tlast)
                            state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_pkt_dispatch.sv
// Directed bench for stream_pkt_dispatch: drivers push expected beats per channel,
// and a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_stream_pkt_dispatch;

    localparam int TU = 128;
    localparam int TD = 256;
    localparam int W  = TU + TD + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    stream_pkt_dispatch_if #(.TUSER_WIDTH(TU), .TDATA_WIDTH(TD)) in_reg ();
    stream_pkt_dispatch_if #(.TUSER_WIDTH(TU), .TDATA_WIDTH(TD)) out0 ();
    stream_pkt_dispatch_if #(.TUSER_WIDTH(TU), .TDATA_WIDTH(TD)) out1 ();

    stream_pkt_dispatch #(
        .TUSER_WIDTH(TU),
        .TDATA_WIDTH(TD),
        .DEST_LSB(0),
        .DEST_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_reg(in_reg),
        .out0(out0),
        .out1(out1),
        .drop_cnt(drop_cnt),
        .err_cnt(err_cnt),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    function automatic logic [TU-1:0] hdr(input logic [1:0] dest, input logic [7:0] tag);
        logic [TU-1:0] h;
        h = '0;
        h[1:0] = dest;
        h[15:8] = tag;
        h[TU-1 -: 8] = ~tag;
        return h;
    endfunction

    function automatic logic [TD-1:0] dat(input logic [31:0] seed);
        logic [TD-1:0] d;
        for (int i = 0; i < 8; i++)
            d[i*32 +: 32] = seed + 32'(i);
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until accepted; ch selects the expected output queue (-1: none).
    task automatic send(input logic s, input logic l, input logic [TU-1:0] u,
                        input logic [TD-1:0] d, input int ch);
        int  waited;
        bit  ok;
        waited = 0;
        ok = 1'b0;
        in_reg.tvalid = 1'b1;
        in_reg.tstart = s;
        in_reg.tlast  = l;
        in_reg.tuser  = u;
        in_reg.tdata  = d;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (in_reg.tready)
                ok = 1'b1;
            else
                waited++;
        end
        n_checks++;
        if (ok) begin
            if (ch == 0)
                exp0_q.push_back({s, l, u, d});
            else if (ch == 1)
                exp1_q.push_back({s, l, u, d});
        end else begin
            n_fail++;
            $display("FAIL send_timeout: beat tag %0h not accepted within 40 cycles", u[15:8]);
        end
        @(posedge clk);
        #1;
        in_reg.tvalid = 1'b0;
    endtask

    // Monitor: a beat leaves an output on the next rising edge whenever tvalid && tready here.
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out0.tvalid && out0.tready) begin
                act = {out0.tstart, out0.tlast, out0.tuser, out0.tdata};
                n_checks++;
                if (exp0_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out0_unexpected: got %h expected no beat", act);
                end else begin
                    exp = exp0_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL out0_beat: got %h expected %h", act, exp);
                    end
                end
            end
            if (!rst && out1.tvalid && out1.tready) begin
                act = {out1.tstart, out1.tlast, out1.tuser, out1.tdata};
                n_checks++;
                if (exp1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out1_unexpected: got %h expected no beat", act);
                end else begin
                    exp = exp1_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL out1_beat: got %h expected %h", act, exp);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        in_reg.tvalid = 1'b1;
        in_reg.tstart = 1'b1;
        in_reg.tlast  = 1'b1;
        in_reg.tuser  = hdr(2'd0, 8'h01);
        in_reg.tdata  = dat(32'h0);
        out0.tready   = 1'b1;
        out1.tready   = 1'b1;

        // Reset state, with a valid beat offered during reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_tready_in_reset", 64'(in_reg.tready), 64'd0);
        check("out0_tvalid_rst", 64'(out0.tvalid), 64'd0);
        check("out1_tvalid_rst", 64'(out1.tvalid), 64'd0);
        check("out0_fields_rst", 64'(|{out0.tstart, out0.tlast, out0.tuser, out0.tdata}), 64'd0);
        check("out1_fields_rst", 64'(|{out1.tstart, out1.tlast, out1.tuser, out1.tdata}), 64'd0);
        check("drop_cnt_rst", 64'(drop_cnt), 64'd0);
        check("err_cnt_rst", 64'(err_cnt), 64'd0);
        check("state_rst", 64'(state_dbg), 64'd0);
        step();
        in_reg.tvalid = 1'b0;
        rst = 1'b0;

        // Single-beat packet to out0
        send(1'b1, 1'b1, hdr(2'd0, 8'h11), dat(32'h1000), 0);
        @(negedge clk);
        check("t1_out0_tvalid", 64'(out0.tvalid), 64'd1);
        check("t1_out0_framing", 64'({out0.tstart, out0.tlast}), 64'd3);
        check("t1_out1_idle", 64'(out1.tvalid), 64'd0);
        @(negedge clk);
        check("t1_out0_one_cycle", 64'(out0.tvalid), 64'd0);

        // 4-beat packet to out1 with a two-cycle downstream stall
        step();
        fork
            begin
                send(1'b1, 1'b0, hdr(2'd1, 8'h22), dat(32'h2000), 1);
                send(1'b0, 1'b0, hdr(2'd1, 8'h22), dat(32'h2001), 1);
                send(1'b0, 1'b0, hdr(2'd1, 8'h22), dat(32'h2002), 1);
                send(1'b0, 1'b1, hdr(2'd1, 8'h22), dat(32'h2003), 1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                out1.tready = 1'b0;
                @(negedge clk);
                check("t2_in_tready_stall", 64'(in_reg.tready), 64'd0);
                check("t2_state_fwd1", 64'(state_dbg), 64'd2);
                check("t2_out1_held", 64'(out1.tvalid), 64'd1);
                @(posedge clk);
                @(posedge clk);
                #1;
                out1.tready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("t2_state_idle", 64'(state_dbg), 64'd0);
        check("t2_out1_drained", 64'(out1.tvalid), 64'd0);

        // 3-beat packet to invalid dest 2, then one beat to out0
        step();
        send(1'b1, 1'b0, hdr(2'd2, 8'h33), dat(32'h3000), -1);
        send(1'b0, 1'b0, hdr(2'd2, 8'h33), dat(32'h3001), -1);
        send(1'b0, 1'b1, hdr(2'd2, 8'h33), dat(32'h3002), -1);
        send(1'b1, 1'b1, hdr(2'd0, 8'h44), dat(32'h4000), 0);
        repeat (2) @(negedge clk);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t3_state_idle", 64'(state_dbg), 64'd0);

        // Two orphan beats in IDLE
        step();
        send(1'b0, 1'b0, hdr(2'd0, 8'h55), dat(32'h5000), -1);
        send(1'b0, 1'b1, hdr(2'd1, 8'h56), dat(32'h5001), -1);
        @(negedge clk);
        check("t4_err_cnt", 64'(err_cnt), 64'd2);
        check("t4_out0_idle", 64'(out0.tvalid), 64'd0);
        check("t4_out1_idle", 64'(out1.tvalid), 64'd0);

        // out0 stuck low: packet A waits in out0, packet B to out1 queues behind it
        out0.tready = 1'b0;
        step();
        fork
            begin
                send(1'b1, 1'b0, hdr(2'd0, 8'h66), dat(32'h6000), 0);
                send(1'b0, 1'b1, hdr(2'd0, 8'h66), dat(32'h6001), 0);
                send(1'b1, 1'b1, hdr(2'd1, 8'h77), dat(32'h7000), 1);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("t5_in_tready_blocked", 64'(in_reg.tready), 64'd0);
                check("t5_state_fwd0", 64'(state_dbg), 64'd1);
                check("t5_out0_beat1_waits", 64'({out0.tvalid, out0.tstart, out0.tlast}), 64'b110);
                check("t5_out1_idle", 64'(out1.tvalid), 64'd0);
                @(posedge clk);
                #1;
                out0.tready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("t5_state_idle", 64'(state_dbg), 64'd0);
        check("t5_out1_drained", 64'(out1.tvalid), 64'd0);

        // Reset mid-packet; the remainder of the packet arrives as orphans
        step();
        out0.tready = 1'b0;
        send(1'b1, 1'b0, hdr(2'd0, 8'h88), dat(32'h8000), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_out0_tvalid_rst", 64'(out0.tvalid), 64'd0);
        check("t6_out0_fields_rst", 64'(|{out0.tstart, out0.tlast, out0.tuser, out0.tdata}), 64'd0);
        check("t6_drop_cnt_rst", 64'(drop_cnt), 64'd0);
        check("t6_err_cnt_rst", 64'(err_cnt), 64'd0);
        check("t6_state_rst", 64'(state_dbg), 64'd0);
        exp0_q.delete();
        step();
        rst = 1'b0;
        out0.tready = 1'b1;
        send(1'b0, 1'b0, hdr(2'd0, 8'h88), dat(32'h8001), -1);
        send(1'b0, 1'b1, hdr(2'd0, 8'h88), dat(32'h8002), -1);
        @(negedge clk);
        check("t6_err_cnt_orphans", 64'(err_cnt), 64'd2);
        check("t6_out0_idle", 64'(out0.tvalid), 64'd0);

        // Drop counter saturation: one single-beat drop per cycle
        step();
        in_reg.tvalid = 1'b1;
        in_reg.tstart = 1'b1;
        in_reg.tlast  = 1'b1;
        in_reg.tuser  = hdr(2'd3, 8'h99);
        in_reg.tdata  = dat(32'h9000);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("sat_drop_cnt_full", 64'(drop_cnt), 64'hFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sat_drop_cnt_hold", 64'(drop_cnt), 64'hFFFF);
        check("sat_state_idle", 64'(state_dbg), 64'd0);
        #1;
        in_reg.tvalid = 1'b0;

        repeat (5) @(negedge clk);
        check("out0_queue_empty", 64'(exp0_q.size()), 64'd0);
        check("out1_queue_empty", 64'(exp1_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_pkt_dispatch.md
# stream_pkt_dispatch

Packet dispatcher that sits directly downstream of the header/payload stream FIFO and consumes its `in_reg_*` output stream. On each packet's start beat it decodes a destination field from `tuser`. It then forwards the whole packet, beat by beat, to one of two registered output channels, or silently drops it. Orphan beats that arrive outside a packet are discarded, and saturating counters record drops and errors.

## Interface
- `TUSER_WIDTH`, 128: header/sideband width, carried unchanged on every beat.
- `TDATA_WIDTH`, 256: payload width.
- `DEST_LSB`, 0: bit position of the destination field in `tuser`.
- `DEST_WIDTH`, 2: width of the destination field (≥1). Value 0 routes to out0, 1 to out1, any other value drops the packet.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_reg_tvalid`  in  1  input beat valid.
- `in_reg_tstart`  in  1  first beat of a packet.
- `in_reg_tlast`  in  1  last beat of a packet.
- `in_reg_tuser`  in  TUSER_WIDTH  header.
- `in_reg_tdata`  in  TDATA_WIDTH  payload.
- `in_reg_tready`  out  1  beat accepted this cycle.
- `outN_tvalid`, N = 0/1  out  1  output beat valid.
- `outN_tstart`, `outN_tlast`  out  1  packet framing.
- `outN_tuser`  out  TUSER_WIDTH  header.
- `outN_tdata`  out  TDATA_WIDTH  payload.
- `outN_tready`  in  1  downstream accepts.
- `drop_cnt`  out  16  packets dropped for an invalid destination; saturates at 0xFFFF.
- `err_cnt`  out  16  orphan beats discarded; saturates at 0xFFFF.

## Operation
- State machine: IDLE, FWD0, FWD1, DROP.
- Input handshake: a beat transfers when `in_reg_tvalid && in_reg_tready`.
  - `in_reg_tready` is asserted only while `in_reg_tvalid` is high. It is never asserted speculatively, because upstream pops on ready.
  - In IDLE: `in_reg_tready` = 1 if the beat will be dropped or discarded; otherwise it equals `slotD_free`, where D is the decoded destination.
  - In FWD0/FWD1: `in_reg_tready` equals the current slot's `slot_free`.
  - In DROP: `in_reg_tready` = 1.
- Slot free: `slotN_free = !outN_tvalid || outN_tready`, i.e. the output register is empty or draining this cycle.
- IDLE, accepted beat with `tstart`=1:
  - Decode `dest = tuser[DEST_LSB +: DEST_WIDTH]`.
  - dest 0 or 1: load the beat into outD. If `tlast`=0, go to FWD{dest}; otherwise stay in IDLE.
  - Any other dest: `drop_cnt`++. If `tlast`=0, go to DROP.
- IDLE, accepted beat with `tstart`=0: discard the beat, `err_cnt`++, stay in IDLE.
- FWD0/FWD1:
  - Every accepted beat loads the current output register, copying `tstart` as received.
  - A `tstart`=1 mid-packet is not re-decoded; it is forwarded as a continuation.
  - An accepted `tlast`=1 beat returns the FSM to IDLE.
- DROP: accepted beats are discarded. An accepted `tlast`=1 beat returns the FSM to IDLE.
- Output register: on load, all `outN_*` fields are captured and `outN_tvalid` is set. `outN_tvalid` clears when `outN_tready` is high and there is no load in the same cycle. Simultaneous load and drain keeps `tvalid` = 1 with the new data.
- Only one output is loaded per cycle. The idle output holds its value and is unaffected by the other channel's backpressure.
- Counters saturate at 0xFFFF and never wrap.

## Timing
- Reset state:
  - FSM = IDLE.
  - `outN_tvalid`, `outN_tstart`, `outN_tlast` = 0; `outN_tuser`, `outN_tdata` = 0.
  - `drop_cnt`, `err_cnt` = 0.
  - `in_reg_tready` = 0 during the reset cycle.
- Reset mid-packet aborts the packet: the FSM returns to IDLE, and the remaining beats arrive as orphans counted in `err_cnt`.
- Latency: an input beat accepted at edge k is presented on `outN_*` from edge k, i.e. visible one cycle after acceptance.
- Throughput: 1 beat/cycle per packet when the selected `outN_tready` is held at 1.
- `in_reg_tready` is combinational from `in_reg_tvalid`, `in_reg_tstart`, `in_reg_tuser`, the FSM state, and `outN_tvalid`/`outN_tready`. No combinational path exists from `in_reg_*` to `outN_*`.
- AXI rule: `outN_*` remain stable while `outN_tvalid && !outN_tready`.

## Test plan
- Single-beat packet, dest=0, `out0_tready`=1 → `out0_tvalid` for 1 cycle, one cycle after acceptance, with `tstart`=`tlast`=1 and data matching; out1 stays idle.
- 4-beat packet, dest=1, `out1_tready` low for cycles 2–3 → `in_reg_tready` low while slot1 is full; all 4 beats arrive in order; FSM back in IDLE after the last beat.
- 3-beat packet with dest=2, then 1-beat dest=0 → `drop_cnt`=1; no out1 activity; out0 receives only the second packet.
- Two orphan beats (`tstart`=0) in IDLE → `err_cnt`=2; no output activity.
- Back-to-back packets dest 0 then 1 with `out0_tready` stuck low → the first packet's beat 1 waits in out0; the second packet is not accepted until the first packet's `tlast` is forwarded.
- Reset asserted mid-packet → all outputs and counters 0 next cycle; the remaining beats are counted as `err_cnt`. Saturation check: preload 0xFFFF drops → `drop_cnt` stays 0xFFFF.
